jk_bank_ctrl: RTL and testbench

Command-driven controller that sequences a bank of N JK flip-flops (instances of the team's `flipflopjk`) as a programmable register/counter. It accepts one command at a time over a valid/ready handshake and drives the bank's J, K, CE, R and S pins for one or more clock edges. It reads the bank's Q back to compute count and shift excitations and to verify contents. It sits between the problem-level control FSM and the flip-flop datapath.

---
 rtl/jk_ctrl_pkg.sv | 24 ++
 rtl/flipflopjk.sv | 28 ++
 rtl/jk_excite_decode.sv | 65 ++++++
 rtl/jk_bank_ctrl.sv | 96 +++++++++
 tb/tb_jk_bank_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared opcodes, FSM encoding and iteration-count rule for the JK bank controller.
package jk_ctrl_pkg;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_PRESET = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_TOGGLE = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;
   localparam logic [2:0] OP_SHIFT  = 3'd6;
   localparam logic [2:0] OP_VERIFY = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // COUNT and SHIFT repeat cmd_count+1 times; every other op runs once.
   function automatic logic op_repeats(input logic [2:0] op);
      return (op == OP_COUNT) || (op == OP_SHIFT);
   endfunction

endpackage

// File: rtl/flipflopjk.sv
// Single JK flip-flop with synchronous reset (priority), set and clock enable.
module flipflopjk (
   input  logic Clk,
   input  logic J,
   input  logic K,
   input  logic CE,
   input  logic R,
   input  logic S,
   output logic Q
);

   // R beats S beats the enabled JK update.
   always_ff @(posedge Clk) begin
      if (R)
         Q <= 1'b0;
      else if (S)
         Q <= 1'b1;
      else if (CE) begin
         case ({J, K})
            2'b01:   Q <= 1'b0;
            2'b10:   Q <= 1'b1;
            2'b11:   Q <= ~Q;
            default: Q <= Q;
         endcase
      end
   end

endmodule

// File: rtl/jk_excite_decode.sv
// Combinational J/K/CE/S/R-term excitation for the latched op, gated by DRIVE.
module jk_excite_decode
   import jk_ctrl_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] data,
   input  logic [N-1:0] q,
   input  logic         active,
   output logic [N-1:0] j,
   output logic [N-1:0] k,
   output logic [N-1:0] ce,
   output logic         s,
   output logic         r_term
);

   logic carry;

   // Per-op excitation; everything idles at zero when not driving.
   always_comb begin
      j      = '0;
      k      = '0;
      ce     = '0;
      s      = 1'b0;
      r_term = 1'b0;
      carry  = 1'b1;
      if (active) begin
         case (op)
            OP_CLEAR:  r_term = 1'b1;
            OP_PRESET: s = 1'b1;
            OP_LOAD: begin
               j  = data;
               k  = ~data;
               ce = '1;
            end
            OP_TOGGLE: begin
               j  = data;
               k  = data;
               ce = data;
            end
            OP_COUNT: begin
               // Bit i toggles when all lower bits are one (ripple-carry prefix AND).
               ce = '1;
               for (int i = 0; i < N; i++) begin
                  j[i]  = carry;
                  k[i]  = carry;
                  carry = carry & q[i];
               end
            end
            OP_SHIFT: begin
               ce   = '1;
               j[0] = data[0];
               k[0] = ~data[0];
               for (int i = 1; i < N; i++) begin
                  j[i] = q[i-1];
                  k[i] = ~q[i-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of N JK flip-flops.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, and the requester holds op/data/count stable
// until that edge. Nothing is captured while cmd_ready is low.
module jk_bank_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = 4
) (
   input  logic          Clk,
   input  logic          R,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [N-1:0]  cmd_data,
   input  logic [CW-1:0] cmd_count,
   input  logic [N-1:0]  q_in,
   output logic [N-1:0]  bank_J,
   output logic [N-1:0]  bank_K,
   output logic [N-1:0]  bank_CE,
   output logic          bank_R,
   output logic          bank_S,
   output logic          done,
   output logic          match,
   output logic [1:0]    fsm_state
);

   state_t        state, state_nx;
   logic [2:0]    op_q;
   logic [N-1:0]  data_q;
   logic [CW-1:0] iter_q;
   logic          accept;
   logic          r_term;

   assign cmd_ready = (state == S_IDLE) && R;
   assign accept    = cmd_valid && cmd_ready;
   assign done      = (state == S_DONE);
   assign fsm_state = state;
   assign bank_R    = ~R | r_term;

   // State register; reset abandons any command in flight.
   always_ff @(posedge Clk or negedge R) begin
      if (!R)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state: IDLE waits for a transfer, DRIVE runs until the counter hits 0.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_DRIVE;
         S_DRIVE: if (iter_q == '0) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Command latch and iteration counter (loaded with remaining iterations minus one).
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         op_q   <= OP_NOP;
         data_q <= '0;
         iter_q <= '0;
      end else if (accept) begin
         op_q   <= cmd_op;
         data_q <= cmd_data;
         iter_q <= op_repeats(cmd_op) ? cmd_count : '0;
      end else if ((state == S_DRIVE) && (iter_q != '0)) begin
         iter_q <= iter_q - 1'b1;
      end
   end

   // VERIFY result is sampled on its single DRIVE edge and held until the next VERIFY.
   always_ff @(posedge Clk or negedge R) begin
      if (!R)
         match <= 1'b0;
      else if ((state == S_DRIVE) && (op_q == OP_VERIFY))
         match <= (q_in == data_q);
   end

   jk_excite_decode #(.N(N)) u_decode (
      .op     (op_q),
      .data   (data_q),
      .q      (q_in),
      .active (state == S_DRIVE),
      .j      (bank_J),
      .k      (bank_K),
      .ce     (bank_CE),
      .s      (bank_S),
      .r_term (r_term)
   );

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl driving a real bank of flipflopjk instances.
module tb_jk_bank_ctrl;
   import jk_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int CW = 4;

   logic          Clk = 1'b0;
   logic          R = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = 3'd0;
   logic [N-1:0]  cmd_data = '0;
   logic [CW-1:0] cmd_count = '0;
   logic [N-1:0]  q;
   logic [N-1:0]  bank_J, bank_K, bank_CE;
   logic          bank_R, bank_S, done, match;
   logic [1:0]    fsm_state;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic [N-1:0]  model_q;
   logic          model_match;
   logic [N-1:0]  exp_q[$];

   logic          hold_en = 1'b0;
   logic [2:0]    hold_op = 3'd0;
   logic [N-1:0]  hold_data = '0;
   logic [CW-1:0] hold_count = '0;

   // Clock
   always #5 Clk = ~Clk;

   jk_bank_ctrl #(.N(N), .CW(CW)) dut (
      .Clk       (Clk),
      .R         (R),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .q_in      (q),
      .bank_J    (bank_J),
      .bank_K    (bank_K),
      .bank_CE   (bank_CE),
      .bank_R    (bank_R),
      .bank_S    (bank_S),
      .done      (done),
      .match     (match),
      .fsm_state (fsm_state)
   );

   for (genvar gi = 0; gi < N; gi++) begin : g_bank
      flipflopjk u_ff (
         .Clk (Clk),
         .J   (bank_J[gi]),
         .K   (bank_K[gi]),
         .CE  (bank_CE[gi]),
         .R   (bank_R),
         .S   (bank_S),
         .Q   (q[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Register contents after one iteration of an op, from the op's meaning.
   function automatic logic [N-1:0] step(input logic [2:0] op, input logic [N-1:0] d,
                                         input logic [N-1:0] v);
      logic [N-1:0] r;
      case (op)
         OP_CLEAR:  r = '0;
         OP_PRESET: r = '1;
         OP_LOAD:   r = d;
         OP_TOGGLE: r = v ^ d;
         OP_COUNT:  r = v + 1'b1;
         OP_SHIFT:  r = (v << 1) | {{(N-1){1'b0}}, d[0]};
         default:   r = v;
      endcase
      return r;
   endfunction

   // Issue one command (called just after a falling edge) and check it cycle by cycle.
   task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] d, input logic [CW-1:0] c);
      int n;
      logic [N-1:0] v;
      n = ((op == OP_COUNT) || (op == OP_SHIFT)) ? int'(c) + 1 : 1;
      v = model_q;
      for (int i = 0; i < n; i++) begin
         v = step(op, d, v);
         exp_q.push_back(v);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_count = c;
      #1 check("ready_before", cmd_ready, 1);
      @(negedge Clk);
      if (hold_en) begin
         cmd_op    = hold_op;
         cmd_data  = hold_data;
         cmd_count = hold_count;
      end else begin
         cmd_valid = 1'b0;
      end
      check("ready_busy", cmd_ready, 0);
      check("done_c1", done, 0);
      for (int cyc = 2; cyc <= n + 1; cyc++) begin
         @(negedge Clk);
         check("q_iter", q, exp_q.pop_front());
         check("done_cyc", done, (cyc == n + 1));
      end
      if (op == OP_VERIFY) model_match = (model_q == d);
      model_q = v;
      check("match", match, model_match);
      check("ce_idle", bank_CE, 0);
      check("ready_in_done", cmd_ready, 0);
      @(negedge Clk);
      check("done_after", done, 0);
      check("ready_after", cmd_ready, 1);
   endtask

   initial begin
      model_q     = '0;
      model_match = 1'b0;

      // Reset state
      repeat (2) @(negedge Clk);
      check("rst_ready", cmd_ready, 0);
      check("rst_done", done, 0);
      check("rst_match", match, 0);
      check("rst_bank_r", bank_R, 1);
      check("rst_jkce", {bank_J, bank_K, bank_CE}, 0);
      check("rst_s", bank_S, 0);
      check("rst_q", q, 0);
      R = 1'b1;
      #1 check("ready_out_of_rst", cmd_ready, 1);
      check("bank_r_released", bank_R, 0);

      // Directed scenarios
      run_cmd(OP_LOAD, 4'b1010, 0);
      run_cmd(OP_LOAD, 4'b1110, 0);
      run_cmd(OP_COUNT, 4'b0000, 3);
      run_cmd(OP_LOAD, 4'b0101, 0);
      run_cmd(OP_SHIFT, 4'b0001, 1);
      run_cmd(OP_LOAD, 4'b1001, 0);
      run_cmd(OP_TOGGLE, 4'b0011, 0);
      run_cmd(OP_VERIFY, 4'b1010, 0);
      run_cmd(OP_VERIFY, 4'b1011, 0);
      run_cmd(OP_PRESET, 4'b0000, 0);
      run_cmd(OP_CLEAR, 4'b1111, 0);
      run_cmd(OP_COUNT, 4'b0000, 15);

      // Busy: a different command is held on the bus while COUNT runs
      hold_en    = 1'b1;
      hold_op    = OP_TOGGLE;
      hold_data  = 4'b1111;
      hold_count = 4'd5;
      run_cmd(OP_COUNT, 4'b0000, 2);
      hold_en = 1'b0;
      run_cmd(OP_TOGGLE, 4'b1111, 5);
      run_cmd(OP_VERIFY, model_q, 0);

      // Reset during iteration 2 of a long COUNT
      cmd_valid = 1'b1;
      cmd_op    = OP_COUNT;
      cmd_data  = '0;
      cmd_count = 4'd7;
      @(negedge Clk);
      cmd_valid = 1'b0;
      @(negedge Clk);
      check("abort_q_iter1", q, model_q + 1'b1);
      R = 1'b0;
      #1 check("abort_state", fsm_state, S_IDLE);
      check("abort_done", done, 0);
      check("abort_match", match, 0);
      check("abort_bank_r", bank_R, 1);
      check("abort_ce", bank_CE, 0);
      @(negedge Clk);
      check("abort_q_clear", q, 0);
      check("abort_done2", done, 0);
      @(negedge Clk);
      check("abort_done3", done, 0);
      model_q     = '0;
      model_match = 1'b0;
      // Command presented in the same cycle reset releases
      R = 1'b1;
      run_cmd(OP_LOAD, 4'b0110, 0);

      // Randomized commands against the model
      for (int t = 0; t < 24; t++) begin
         run_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
